// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell shared across WIDTH clocks, LSB first,
// with valid/ready handshakes on the operand and result sides.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             carry, carry_nxt;
  logic [WIDTH-1:0] sh_a, sh_a_nxt;
  logic [WIDTH-1:0] sh_b, sh_b_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt, ovf_nxt;
  logic             res_valid_nxt, busy_nxt, start_ready_nxt;
  logic             fa_sum, fa_co;

  full_adder u_fa (
    .a   (sh_a[0]),
    .b   (sh_b[0]),
    .ci  (carry),
    .sum (fa_sum),
    .co  (fa_co)
  );

  // State and datapath registers; start_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      sh_a        <= '0;
      sh_b        <= '0;
      sum         <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      carry       <= carry_nxt;
      sh_a        <= sh_a_nxt;
      sh_b        <= sh_b_nxt;
      sum         <= sum_nxt;
      cout        <= cout_nxt;
      ovf         <= ovf_nxt;
      res_valid   <= res_valid_nxt;
      busy        <= busy_nxt;
      start_ready <= start_ready_nxt;
    end
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    carry_nxt = carry;
    sh_a_nxt  = sh_a;
    sh_b_nxt  = sh_b;
    sum_nxt   = sum;
    cout_nxt  = cout;
    ovf_nxt   = ovf;

    case (state)
      IDLE: begin
        if (start_valid && start_ready) begin
          sh_a_nxt  = op_a;
          sh_b_nxt  = op_b;
          carry_nxt = cin;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        sh_a_nxt  = sh_a >> 1;
        sh_b_nxt  = sh_b >> 1;
        sum_nxt   = {fa_sum, sum[WIDTH-1:1]};
        carry_nxt = fa_co;
        if (cnt == CW'(WIDTH - 1)) begin
          // Last bit: carry into the MSB is the carry flop, carry out is the cell's co.
          cout_nxt  = fa_co;
          ovf_nxt   = carry ^ fa_co;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    start_ready_nxt = (state_nxt == IDLE);
    busy_nxt        = (state_nxt != IDLE);
    res_valid_nxt   = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): cycle-level behavioural model,
// per-cycle comparison, directed literal cases and randomized back-to-back traffic.

module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    int u;
    int s;
    logic v;
    u = int'(a) + int'(b) + int'(c);
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    v = (s > 127) || (s < -128);
    return {v, u[W:0]};
  endfunction

  // Behavioural model: one outstanding operation, result visible WIDTH edges after accept.
  logic           m_ready = 1'b0;
  logic           m_valid = 1'b0;
  logic           m_busy  = 1'b0;
  int             m_left  = 0;
  logic [W-1:0]   m_sum   = '0;
  logic           m_cout  = 1'b0;
  logic           m_ovf   = 1'b0;
  logic [W+1:0]   p_res   = '0;
  int             n_acc   = 0;
  int             n_res   = 0;
  logic [W+1:0]   exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b0;
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_left  <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
      exp_q.delete();
    end else if (m_ready) begin
      if (start_valid) begin
        p_res   <= ref_add(op_a, op_b, cin);
        exp_q.push_back(ref_add(op_a, op_b, cin));
        n_acc   <= n_acc + 1;
        m_ready <= 1'b0;
        m_busy  <= 1'b1;
        m_left  <= W;
      end
    end else if (m_valid) begin
      if (res_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
      end
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_sum   <= p_res[W-1:0];
        m_cout  <= p_res[W];
        m_ovf   <= p_res[W+1];
      end
      m_left <= m_left - 1;
    end else begin
      m_ready <= 1'b1;
    end
  end

  // Compare DUT to model on every falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("start_ready", 32'(start_ready), 32'(m_ready));
      chk("res_valid", 32'(res_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("cout", 32'(cout), 32'(m_cout));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (!m_busy || m_valid) chk("sum", 32'(sum), 32'(m_sum));
      if (res_valid && res_ready) begin
        n_res++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(1), 32'(0));
        end else begin
          chk("scoreboard", 32'({ovf, cout, sum}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!start_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("start_ready_wait", 32'(start_ready), 32'(1));
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W:0] exp_res, input logic exp_ovf,
                       input int stall, input bit poke);
    int n;
    wait_ready();
    op_a = a; op_b = b; cin = c; start_valid = 1'b1;
    @(posedge clk); #2;
    start_valid = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
    // The accept edge counts as edge 1.
    n = 1;
    while (!res_valid && n < 40) begin
      if (poke && n == 3) begin
        start_valid = 1'b1; op_a = 8'hAA; op_b = 8'h55; cin = 1'b1;
      end
      @(posedge clk); #2;
      start_valid = 1'b0;
      if (poke) chk("busy_in_run", 32'(busy), 32'(1));
      n++;
    end
    chk("latency_edges", 32'(n), 32'(W + 1));
    chk("lit_sum", 32'(sum), 32'(exp_res[W-1:0]));
    chk("lit_cout", 32'(cout), 32'(exp_res[W]));
    chk("lit_ovf", 32'(ovf), 32'(exp_ovf));
    repeat (stall) begin
      @(posedge clk); #2;
      chk("hold_valid", 32'(res_valid), 32'(1));
      chk("hold_result", 32'({cout, sum}), 32'(exp_res));
    end
    res_ready = 1'b1;
    @(posedge clk); #2;
    res_ready = 1'b0;
    chk("post_start_ready", 32'(start_ready), 32'(1));
    chk("post_res_valid", 32'(res_valid), 32'(0));
  endtask

  initial begin
    int cyc;
    int a0;
    int r0;
    start_valid = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0;
    res_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    do_op(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 9'h100, 1'b1, 2, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0, 5, 1'b0);
    do_op(8'h12, 8'h34, 1'b1, 9'h047, 1'b0, 1, 1'b1);

    // Abort in the middle of RUN: outputs must clear without a clock edge.
    wait_ready();
    op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1; start_valid = 1'b1;
    @(posedge clk); #2;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    chk("abort_ovf", 32'(ovf), 32'(0));
    chk("abort_res_valid", 32'(res_valid), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_start_ready", 32'(start_ready), 32'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    do_op(8'h05, 8'h03, 1'b0, 9'h008, 1'b0, 0, 1'b0);

    // Randomized back-to-back traffic with random consumer stalls.
    a0 = n_acc;
    r0 = n_res;
    cyc = 0;
    while (((n_acc - a0) < 200 || m_busy) && cyc < 20000) begin
      @(posedge clk); #2;
      start_valid = ((n_acc - a0) < 200);
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      cin  = 1'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    start_valid = 1'b0;
    res_ready = 1'b0;
    chk("rand_no_timeout", 32'(cyc < 20000), 32'(1));
    chk("rand_accepts", 32'(n_acc - a0), 32'(200));
    chk("rand_results", 32'(n_res - r0), 32'(n_acc - a0));
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
